div_share_ctrl: RTL and testbench

- Controller that shares one iterative restoring divider (4-cycle shift/subtract plus 1 result cycle) between two requesters.
- Round-robin arbitration between the two requesters. Captures the granted requester's operands and launches the divider with a one-cycle Go pulse.
- Waits for divider completion (or timeout), then returns quotient/remainder to the granted requester with a one-cycle Done pulse.
- Handles divide-by-zero locally, without launching the divider.

---
 rtl/div_share_ctrl_pkg.sv | 20 ++
 rtl/div_share_ctrl_if.sv | 40 ++++
 rtl/div_share_ctrl_rr_arb2.sv | 25 ++
 rtl/div_share_ctrl.sv | 155 +++++++++++++++
 tb/tb_div_share_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/div_share_ctrl_pkg.sv
// Shared definitions for the two-requester divider sharing controller:
// FSM encoding, default sizes and the timeout counter width helper.
package div_share_ctrl_pkg;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Counter only needs to reach TIMEOUT-1.
  function automatic int tmo_cnt_w(input int timeout);
    return $clog2(timeout);
  endfunction

endpackage

// File: rtl/div_share_ctrl_if.sv
// Requester and divider-side signals of div_share_ctrl. The controller
// takes the slave view; requesters plus divider (or a bench) take master.
interface div_share_ctrl_if
  import div_share_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             req0, req1;
  logic [WIDTH-1:0] divisor0, divisor1;
  logic [WIDTH-1:0] dividend0, dividend1;
  logic             ack0, ack1;
  logic             done0, done1;
  logic             err0, err1;
  logic [WIDTH-1:0] quotient0, quotient1;
  logic [WIDTH:0]   remainder0, remainder1;
  logic             busy;
  logic             div_go;
  logic [WIDTH-1:0] div_divisor, div_dividend;
  logic             div_done;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH:0]   div_remainder;

  modport slave (
    input  req0, req1, divisor0, divisor1, dividend0, dividend1,
    input  div_done, div_quotient, div_remainder,
    output ack0, ack1, done0, done1, err0, err1,
    output quotient0, quotient1, remainder0, remainder1,
    output busy, div_go, div_divisor, div_dividend
  );

  modport master (
    output req0, req1, divisor0, divisor1, dividend0, dividend1,
    output div_done, div_quotient, div_remainder,
    input  ack0, ack1, done0, done1, err0, err1,
    input  quotient0, quotient1, remainder0, remainder1,
    input  busy, div_go, div_divisor, div_dividend
  );

endinterface

// File: rtl/div_share_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter. The pointer remembers the last grant
// and only advances when the owner commits a grant via upd.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic upd,
  output logic gnt
);

  logic last;

  // A tie goes to whoever was not served last; a lone request wins outright.
  always_comb gnt = (req0 && req1) ? ~last : ~req0;

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (upd) begin
      last <= gnt;
    end
  end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one iterative divider between two requesters: arbitrates, launches
// the divider, then returns quotient/remainder (or an error) to the winner.
module div_share_ctrl
  import div_share_ctrl_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic             clk,
  input logic             rst,
  div_share_ctrl_if.slave bus
);

  localparam int CNT_W = tmo_cnt_w(TIMEOUT);

  state_t           state, state_nxt;
  logic             gnt, gnt_q, grant_en;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] div_divisor_q, div_dividend_q;
  logic [WIDTH-1:0] quot0_q, quot1_q;
  logic [WIDTH:0]   rem0_q, rem1_q;
  logic             err0_q, err1_q;
  logic             ld_res;
  logic [WIDTH-1:0] res_quot;
  logic [WIDTH:0]   res_rem;
  logic             res_err;
  logic             divisor_zero;

  assign divisor_zero = (div_divisor_q == '0);

  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req0 (bus.req0),
    .req1 (bus.req1),
    .upd  (grant_en),
    .gnt  (gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    ld_res    = 1'b0;
    res_quot  = '0;
    res_rem   = '0;
    res_err   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          grant_en  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (divisor_zero) begin
          // Answered locally; the divider is never started.
          ld_res    = 1'b1;
          res_quot  = '1;
          res_rem   = {1'b0, div_dividend_q};
          res_err   = 1'b1;
          state_nxt = RESP;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // Completion takes priority over a timeout in the same cycle.
        if (bus.div_done) begin
          ld_res    = 1'b1;
          res_quot  = bus.div_quotient;
          res_rem   = bus.div_remainder;
          state_nxt = RESP;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          ld_res    = 1'b1;
          res_err   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == ISSUE) begin
      cnt <= '0;
    end else if (state == WAIT) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Operands are frozen at the grant edge and stay put until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q          <= 1'b0;
      div_divisor_q  <= '0;
      div_dividend_q <= '0;
    end else if (grant_en) begin
      gnt_q          <= gnt;
      div_divisor_q  <= gnt ? bus.divisor1  : bus.divisor0;
      div_dividend_q <= gnt ? bus.dividend1 : bus.dividend0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quot0_q <= '0;
      rem0_q  <= '0;
      err0_q  <= 1'b0;
      quot1_q <= '0;
      rem1_q  <= '0;
      err1_q  <= 1'b0;
    end else if (ld_res) begin
      if (gnt_q) begin
        quot1_q <= res_quot;
        rem1_q  <= res_rem;
        err1_q  <= res_err;
      end else begin
        quot0_q <= res_quot;
        rem0_q  <= res_rem;
        err0_q  <= res_err;
      end
    end
  end

  assign bus.ack0         = (state == ISSUE) && !gnt_q;
  assign bus.ack1         = (state == ISSUE) &&  gnt_q;
  assign bus.done0        = (state == RESP)  && !gnt_q;
  assign bus.done1        = (state == RESP)  &&  gnt_q;
  assign bus.div_go       = (state == ISSUE) && !divisor_zero;
  assign bus.busy         = (state != IDLE);
  assign bus.div_divisor  = div_divisor_q;
  assign bus.div_dividend = div_dividend_q;
  assign bus.quotient0    = quot0_q;
  assign bus.quotient1    = quot1_q;
  assign bus.remainder0   = rem0_q;
  assign bus.remainder1   = rem1_q;
  assign bus.err0         = err0_q;
  assign bus.err1         = err1_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Randomized scoreboard bench for div_share_ctrl with a behavioural divider
// whose Go-to-Done delay is programmable (0 means it never answers).
module tb_div_share_ctrl;
  import div_share_ctrl_pkg::*;

  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 16;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH:0]   r;
    logic             err;
    int               lat;
    int               ack_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_share_ctrl_if #(.WIDTH(WIDTH)) bus ();

  div_share_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   dm_d   = 5;
  exp_t sb0[$];
  exp_t sb1[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference result from the arithmetic rules, independent of any FSM detail.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input int d, input int ack_cyc);
    exp_t e;
    e.ack_cyc = ack_cyc;
    if (b == 0) begin
      e.q = '1; e.r = {1'b0, a}; e.err = 1'b1; e.lat = 1;
    end else if (d == 0 || d > TIMEOUT) begin
      e.q = '0; e.r = '0; e.err = 1'b1; e.lat = TIMEOUT + 1;
    end else begin
      e.q = a / b; e.r = a % b; e.err = 1'b0; e.lat = d + 1;
    end
    return e;
  endfunction

  // Divider: Done sits in the D-th cycle after the Go cycle.
  int               dm_cnt = 0;
  logic [WIDTH-1:0] dm_q;
  logic [WIDTH:0]   dm_r;
  initial begin
    bus.div_done = 1'b0; bus.div_quotient = '0; bus.div_remainder = '0;
    forever begin
      @(negedge clk);
      bus.div_done      = 1'b0;
      bus.div_quotient  = WIDTH'($urandom);
      bus.div_remainder = (WIDTH+1)'($urandom);
      if (dm_cnt > 0) begin
        dm_cnt--;
        if (dm_cnt == 0) begin
          bus.div_done = 1'b1; bus.div_quotient = dm_q; bus.div_remainder = dm_r;
        end
      end
      if (bus.div_go === 1'b1 && dm_d != 0 && bus.div_divisor != 0) begin
        dm_cnt = dm_d;
        dm_q   = bus.div_dividend / bus.div_divisor;
        dm_r   = (WIDTH+1)'(bus.div_dividend % bus.div_divisor);
      end
    end
  end

  task automatic drive(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bit got = 0;
    @(posedge clk); #1;
    if (idx == 0) begin bus.req0 = 1'b1; bus.dividend0 = a; bus.divisor0 = b; end
    else          begin bus.req1 = 1'b1; bus.dividend1 = a; bus.divisor1 = b; end
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if ((idx == 0 ? bus.ack0 : bus.ack1) === 1'b1) begin
        got = 1;
        if (idx == 0) sb0.push_back(model(a, b, dm_d, cyc));
        else          sb1.push_back(model(a, b, dm_d, cyc));
      end
    end
    if (!got) begin
      n_cmp++; n_fail++;
      $display("FAIL ack_wait%0d: no ack within 100 cycles", idx);
    end
    @(posedge clk); #1;
    // Inputs after capture must have no effect on the result.
    if (idx == 0) begin bus.req0 = 1'b0; bus.dividend0 = WIDTH'($urandom); bus.divisor0 = WIDTH'($urandom); end
    else          begin bus.req1 = 1'b0; bus.dividend1 = WIDTH'($urandom); bus.divisor1 = WIDTH'($urandom); end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) ok = 1;
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL idle_wait: busy still high after 60 cycles");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Monitor: arbitration, handshake, divider port and result checks.
  logic             pr0 = 0, pr1 = 0;
  logic [WIDTH-1:0] pa0, pb0, pa1, pb1;
  bit               armed = 0, rst_prev = 0, inflight = 0, want_ack = 0, last = 1;
  bit               cur_g, busy_exp;
  logic [WIDTH-1:0] cur_a, cur_b;
  logic [WIDTH-1:0] hq [2];
  logic [WIDTH:0]   hr [2];
  logic             he [2];

  initial begin
    exp_t e;
    bit   g, eg, dn;
    forever begin
      @(negedge clk);
      if (rst_prev) begin
        armed = 1; inflight = 0; want_ack = 0; last = 1;
        sb0.delete(); sb1.delete();
        for (int i = 0; i < 2; i++) begin hq[i] = '0; hr[i] = '0; he[i] = 1'b0; end
        check("rst_ack",  {bus.ack0, bus.ack1, bus.done0, bus.done1}, 0);
        check("rst_err",  {bus.err0, bus.err1}, 0);
        check("rst_res",  {bus.quotient0, bus.quotient1, bus.remainder0, bus.remainder1}, 0);
        check("rst_busy", {bus.busy, bus.div_go}, 0);
        check("rst_div",  {bus.div_divisor, bus.div_dividend}, 0);
      end else if (armed) begin
        check("ack_expected", bus.ack0 | bus.ack1, want_ack);
        check("ack_both", bus.ack0 & bus.ack1, 0);
        if (bus.ack0 ^ bus.ack1) begin
          g  = bus.ack1;
          eg = (pr0 && pr1) ? !last : !pr0;
          check("grant", g, eg);
          last = eg; cur_g = g; inflight = 1;
          cur_a = g ? pa1 : pa0;
          cur_b = g ? pb1 : pb0;
        end
        busy_exp = inflight;
        check("busy", bus.busy, busy_exp);
        check("div_go", bus.div_go, (bus.ack0 | bus.ack1) && cur_b != 0);
        if (inflight) begin
          check("div_divisor",  bus.div_divisor,  cur_b);
          check("div_dividend", bus.div_dividend, cur_a);
        end
        for (int i = 0; i < 2; i++) begin
          dn = (i == 0) ? bus.done0 : bus.done1;
          if (dn) begin
            check("done_owner", inflight && cur_g == i, 1);
            if ((i == 0 ? sb0.size() : sb1.size()) == 0) begin
              n_cmp++; n_fail++;
              $display("FAIL done_unexpected%0d: Done with nothing outstanding", i);
            end else begin
              e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
              check("latency", cyc - e.ack_cyc, e.lat);
              hq[i] = e.q; hr[i] = e.r; he[i] = e.err;
            end
          end
        end
        if (bus.done0 | bus.done1) inflight = 0;
        check("quotient0",  bus.quotient0,  hq[0]);
        check("remainder0", bus.remainder0, hr[0]);
        check("err0",       bus.err0,       he[0]);
        check("quotient1",  bus.quotient1,  hq[1]);
        check("remainder1", bus.remainder1, hr[1]);
        check("err1",       bus.err1,       he[1]);
        want_ack = !busy_exp && (bus.req0 || bus.req1);
      end
      pr0 = bus.req0; pr1 = bus.req1;
      pa0 = bus.dividend0; pb0 = bus.divisor0;
      pa1 = bus.dividend1; pb1 = bus.divisor1;
      rst_prev = rst;
    end
  end

  initial begin
    bit p0, p1;
    int d0, d1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.divisor0 = '0; bus.divisor1 = '0; bus.dividend0 = '0; bus.dividend1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    dm_d = 5;  drive(0, 4'd7, 4'd2); wait_idle();
    pulse_reset();
    fork drive(0, 4'd9, 4'd4); drive(1, 4'd15, 4'd3); join
    wait_idle();
    fork drive(0, 4'd12, 4'd5); drive(1, 4'd14, 4'd4); join
    wait_idle();
    drive(1, 4'd13, 4'd0); wait_idle();
    dm_d = 0;  drive(0, 4'd5, 4'd1); wait_idle();

    // Reset lands in the third WAIT cycle; the divider still answers later.
    dm_d = 10; drive(0, 4'd11, 4'd3);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (14) @(posedge clk);
    dm_d = 5;  drive(0, 4'd6, 4'd3); wait_idle();
    drive(0, 4'd8, 4'd2); wait_idle();

    dm_d = TIMEOUT;     drive(1, 4'd15, 4'd2); wait_idle();
    dm_d = TIMEOUT + 1; drive(0, 4'd9, 4'd3);  wait_idle();
    dm_d = 1;           drive(1, 4'd0, 4'd7);  wait_idle();

    for (int n = 0; n < 40; n++) begin
      dm_d = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, TIMEOUT + 2);
      p0 = $urandom_range(0, 3) != 0;
      p1 = $urandom_range(0, 3) != 0;
      if (!p0 && !p1) p0 = 1;
      d0 = $urandom_range(0, 2); d1 = $urandom_range(0, 2);
      a0 = WIDTH'($urandom); a1 = WIDTH'($urandom);
      b0 = ($urandom_range(0, 6) == 0) ? '0 : WIDTH'($urandom);
      b1 = ($urandom_range(0, 6) == 0) ? '0 : WIDTH'($urandom);
      fork
        begin if (p0) begin repeat (d0) @(posedge clk); drive(0, a0, b0); end end
        begin if (p1) begin repeat (d1) @(posedge clk); drive(1, a1, b1); end end
      join
      wait_idle();
    end

    check("sb0_drained", sb0.size(), 0);
    check("sb1_drained", sb1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
